fb_draw_ctrl: RTL

FB_DRAW_CTRL -- requirements
Module: fb_draw_ctrl

---
 rtl/fb_draw_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fb_draw_ctrl.sv
// Two-requester draw controller for a 128-wide, 1-bit frame buffer.
// Accepts PIXEL / HLINE / CLEAR commands and streams one write per cycle.
module fb_draw_ctrl #(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned HEIGHT = 120
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_valid,
    input  logic [23:0] i_cmd0,
    input  logic [23:0] i_cmd1,
    output logic [1:0]  o_ready,
    output logic        o_we,
    output logic [13:0] o_waddr,
    output logic        o_wdata,
    output logic        o_busy,
    output logic        o_err
);

    localparam logic [13:0] LastAddr = 14'(WIDTH * HEIGHT - 1);
    localparam logic [6:0]  YLimit   = 7'(HEIGHT);

    typedef enum logic {StIdle, StRun} state_e;
    typedef enum logic [1:0] {OpNop, OpPixel, OpHline, OpClear} op_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic [13:0] addr_q, addr_d;
    logic [13:0] end_q, end_d;
    logic        color_q, color_d;
    logic        err_q, err_d;

    logic [23:0] cmd;
    logic        grant1;
    op_e         op;
    logic        color;
    logic [6:0]  y, xa, xb, x_start, x_end;

    // last_q names the requester granted most recently; a tie goes to the other one.
    always_comb begin
        o_ready = 2'b00;
        if (!i_rst && state_q == StIdle) begin
            case (i_valid)
                2'b01:   o_ready = 2'b01;
                2'b10:   o_ready = 2'b10;
                2'b11:   o_ready = last_q ? 2'b01 : 2'b10;
                default: o_ready = 2'b00;
            endcase
        end
    end

    assign grant1 = o_ready[1];
    assign cmd    = grant1 ? i_cmd1 : i_cmd0;
    assign op     = op_e'(cmd[23:22]);
    assign color  = cmd[21];
    assign y      = cmd[20:14];
    assign xb     = cmd[13:7];
    assign xa     = cmd[6:0];

    always_comb begin
        x_start = xa;
        x_end   = xa;
        if (op == OpHline) begin
            x_start = (xa < xb) ? xa : xb;
            x_end   = (xa < xb) ? xb : xa;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        addr_d  = addr_q;
        end_d   = end_q;
        color_d = color_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|(i_valid & o_ready)) begin
                    last_d = grant1;
                    unique case (op)
                        OpPixel, OpHline: begin
                            if (y >= YLimit) begin
                                err_d = 1'b1;
                            end else begin
                                state_d = StRun;
                                color_d = color;
                                addr_d  = {y, x_start};
                                end_d   = {y, x_end};
                            end
                        end
                        OpClear: begin
                            state_d = StRun;
                            color_d = color;
                            addr_d  = 14'd0;
                            end_d   = LastAddr;
                        end
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (addr_q == end_q) begin
                    state_d = StIdle;
                end else begin
                    addr_d = addr_q + 14'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            addr_q  <= 14'd0;
            end_q   <= 14'd0;
            color_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            color_q <= color_d;
            err_q   <= err_d;
        end
    end

    // Every RUN cycle is a write cycle, so write enable and busy share the state flop.
    assign o_we    = (state_q == StRun);
    assign o_busy  = (state_q == StRun);
    assign o_waddr = addr_q;
    assign o_wdata = color_q;
    assign o_err   = err_q;

endmodule
